// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port RAM: weighted CPU/debug sharing,
// an exclusive debug lock, and one-cycle read-response routing.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int CPU_WEIGHT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_lock_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_stall_o,
  output logic              locked_o
);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [3:0] WEIGHT = 4'(CPU_WEIGHT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cpu_rd_q, cpu_rd_d;
  logic       dbg_rd_q, dbg_rd_d;
  logic       lock_hold;
  logic       cpu_gnt, dbg_gnt;

  // Lock is only held while debug keeps dbg_lock_i high; the cycle it drops
  // already arbitrates normally so the CPU can win immediately.
  assign lock_hold = (state_q == LOCKED) && dbg_lock_i;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst_i) begin
      if (lock_hold) begin
        dbg_gnt = dbg_req_i;
      end else if (cpu_req_i && dbg_req_i) begin
        if (cnt_q < WEIGHT) cpu_gnt = 1'b1;
        else                dbg_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req_i;
        dbg_gnt = dbg_req_i;
      end
    end
  end

  always_comb begin
    state_d  = (lock_hold || (dbg_gnt && dbg_lock_i)) ? LOCKED : ARB;
    cnt_d    = cnt_q;
    if (dbg_gnt || !dbg_req_i) begin
      cnt_d = 4'd0;
    end else if (cpu_gnt && (cnt_q < WEIGHT)) begin
      cnt_d = cnt_q + 4'd1;
    end
    cpu_rd_d = cpu_gnt && !cpu_we_i;
    dbg_rd_d = dbg_gnt && !dbg_we_i;
  end

  // An in-flight read is dropped by reset because its pending flag is cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB;
      cnt_q    <= 4'd0;
      cpu_rd_q <= 1'b0;
      dbg_rd_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cpu_rd_q <= cpu_rd_d;
      dbg_rd_q <= dbg_rd_d;
    end
  end

  assign cpu_gnt_o    = cpu_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign mem_en_o     = cpu_gnt | dbg_gnt;
  assign mem_we_o     = cpu_gnt ? cpu_we_i    : (dbg_gnt ? dbg_we_i    : 1'b0);
  assign mem_addr_o   = cpu_gnt ? cpu_addr_i  : (dbg_gnt ? dbg_addr_i  : '0);
  assign mem_wdata_o  = cpu_gnt ? cpu_wdata_i : (dbg_gnt ? dbg_wdata_i : '0);

  assign cpu_rvalid_o = cpu_rd_q;
  assign dbg_rvalid_o = dbg_rd_q;
  assign cpu_rdata_o  = cpu_rd_q ? mem_rdata_i : '0;
  assign dbg_rdata_o  = dbg_rd_q ? mem_rdata_i : '0;

  assign cpu_stall_o  = !rst_i && ((cpu_req_i && !cpu_gnt) || lock_hold);
  assign locked_o     = lock_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a cycle-level
// reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int W  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cpu_req_i, cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic          cpu_gnt_o, cpu_rvalid_o;
  logic [DW-1:0] cpu_rdata_o;
  logic          dbg_req_i, dbg_we_i, dbg_lock_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic          dbg_gnt_o, dbg_rvalid_o;
  logic [DW-1:0] dbg_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          cpu_stall_o, locked_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CPU_WEIGHT(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o),
    .cpu_rdata_o(cpu_rdata_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_lock_i(dbg_lock_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .cpu_stall_o(cpu_stall_o), .locked_o(locked_o)
  );

  typedef enum int {G_NONE, G_CPU, G_DBG} who_e;

  int   total = 0;
  int   bad   = 0;
  bit   m_locked;
  int   m_cnt;
  bit   m_cpu_pend, m_dbg_pend;
  who_e last_g;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lock_active();
    return !rst_i && m_locked && dbg_lock_i;
  endfunction

  // Who the rules say owns memory this cycle.
  function automatic who_e pick();
    if (rst_i) return G_NONE;
    if (lock_active()) return dbg_req_i ? G_DBG : G_NONE;
    if (cpu_req_i && dbg_req_i) return (m_cnt < W) ? G_CPU : G_DBG;
    if (cpu_req_i) return G_CPU;
    if (dbg_req_i) return G_DBG;
    return G_NONE;
  endfunction

  task automatic check_outputs();
    who_e          g;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_cv, e_dv, e_stall;
    g      = pick();
    e_we   = (g == G_CPU) ? cpu_we_i    : (g == G_DBG) ? dbg_we_i    : 1'b0;
    e_addr = (g == G_CPU) ? cpu_addr_i  : (g == G_DBG) ? dbg_addr_i  : '0;
    e_wd   = (g == G_CPU) ? cpu_wdata_i : (g == G_DBG) ? dbg_wdata_i : '0;
    e_cv   = !rst_i && m_cpu_pend;
    e_dv   = !rst_i && m_dbg_pend;
    e_stall = !rst_i && ((cpu_req_i && g != G_CPU) || lock_active());
    check("grants", {cpu_gnt_o, dbg_gnt_o}, {g == G_CPU, g == G_DBG});
    check("mem_bus", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o},
          {g != G_NONE, e_we, e_addr, e_wd});
    check("responses", {cpu_rvalid_o, cpu_rdata_o, dbg_rvalid_o, dbg_rdata_o},
          {e_cv, e_cv ? mem_rdata_i : 32'h0, e_dv, e_dv ? mem_rdata_i : 32'h0});
    check("status", {cpu_stall_o, locked_o}, {e_stall, lock_active()});
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_cnt      = 0;
    m_cpu_pend = 1'b0;
    m_dbg_pend = 1'b0;
  endtask

  task automatic advance();
    bit lk;
    last_g = pick();
    lk     = lock_active();
    @(posedge clk_i);
    if (rst_i) begin
      model_reset();
    end else begin
      m_cpu_pend = (last_g == G_CPU) && !cpu_we_i;
      m_dbg_pend = (last_g == G_DBG) && !dbg_we_i;
      m_locked   = lk || ((last_g == G_DBG) && dbg_lock_i);
      if (last_g == G_DBG || !dbg_req_i) m_cnt = 0;
      else if (last_g == G_CPU && m_cnt < W) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk_i);
    check_outputs();
    advance();
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req_i = req; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic lk);
    dbg_req_i = req; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d; dbg_lock_i = lk;
  endtask

  initial begin
    bit cpu_done, dbg_done;
    rst_i = 1'b1;
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_dbg(1'bx, 1'b0, '0, '0, 1'b0);
    mem_rdata_i = 32'h1234_5678;
    model_reset();
    #2;
    check("reset_outputs", {cpu_gnt_o, dbg_gnt_o, mem_en_o, cpu_stall_o, locked_o,
                            cpu_rvalid_o, dbg_rvalid_o}, 7'b0);
    step();
    step();
    rst_i = 1'b0;
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    step();

    // CPU read of 0x10, response next cycle.
    drive_cpu(1'b1, 1'b0, 32'h10, '0);
    @(negedge clk_i);
    check_outputs();
    check("cpu_read_grant", {cpu_gnt_o, mem_en_o, mem_addr_o}, {2'b11, 32'h10});
    advance();
    drive_cpu(1'b0, 1'b0, '0, '0);
    mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check_outputs();
    check("cpu_read_data", {cpu_rvalid_o, cpu_rdata_o, dbg_rvalid_o}, {1'b1, 32'hDEAD_BEEF, 1'b0});
    advance();

    // Weighted contention: C,C,C,C,D repeating.
    for (int i = 0; i < 14; i++) begin
      drive_cpu(1'b1, 1'b1, 32'(i), 32'(i + 100));
      drive_dbg(1'b1, 1'b1, 32'(i + 200), 32'(i + 300), 1'b0);
      @(negedge clk_i);
      check_outputs();
      check("weight_pattern", {cpu_gnt_o, dbg_gnt_o, cpu_stall_o},
            {(i % 5) != 4, (i % 5) == 4, (i % 5) == 4});
      advance();
    end

    // Lock: six debug grants with CPU waiting, then CPU wins when lock drops.
    for (int i = 0; i < 6; i++) begin
      drive_dbg(1'b1, 1'b1, 32'(i), 32'(i), 1'b1);
      @(negedge clk_i);
      check_outputs();
      check("lock_grant", {dbg_gnt_o, cpu_gnt_o, cpu_stall_o, locked_o}, {3'b101, i != 0});
      advance();
    end
    drive_dbg(1'b1, 1'b1, '0, '0, 1'b0);
    @(negedge clk_i);
    check_outputs();
    check("lock_release", {cpu_gnt_o, locked_o}, 2'b10);
    advance();

    // Back-to-back: debug write then CPU read of the same address.
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_dbg(1'b1, 1'b1, 32'h4, 32'h55, 1'b0);
    @(negedge clk_i);
    check_outputs();
    check("b2b_write", {dbg_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o}, {2'b11, 32'h4, 32'h55});
    advance();
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    drive_cpu(1'b1, 1'b0, 32'h4, '0);
    @(negedge clk_i);
    check_outputs();
    check("b2b_read", {cpu_gnt_o, mem_we_o, dbg_rvalid_o}, 3'b100);
    advance();
    drive_cpu(1'b0, 1'b0, '0, '0);
    mem_rdata_i = 32'h55;
    @(negedge clk_i);
    check_outputs();
    check("b2b_rvalid", {cpu_rvalid_o, cpu_rdata_o, dbg_rvalid_o}, {1'b1, 32'h55, 1'b0});
    advance();

    // Reset lands between a granted read and its response.
    drive_cpu(1'b1, 1'b0, 32'h20, '0);
    drive_dbg(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk_i);
    check_outputs();
    #1;
    rst_i = 1'b1;
    dbg_req_i = 1'bx;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check_outputs();
    check("reset_drop", {cpu_rvalid_o, mem_en_o, locked_o, cpu_stall_o}, 4'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive_cpu(1'b1, 1'b0, 32'h30, '0);
    drive_dbg(1'b1, 1'b0, 32'h40, '0, 1'b0);
    @(negedge clk_i);
    check_outputs();
    check("first_after_reset", {cpu_gnt_o, dbg_gnt_o}, 2'b10);
    advance();

    // Randomized traffic; a requester keeps its fields until granted.
    cpu_done = 1'b1;
    dbg_done = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (cpu_done)
        drive_cpu($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom);
      if (dbg_done) begin
        dbg_req_i   = $urandom_range(0, 2) != 0;
        dbg_we_i    = 1'($urandom);
        dbg_addr_i  = $urandom;
        dbg_wdata_i = $urandom;
      end
      dbg_lock_i  = m_locked ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 4) == 0);
      mem_rdata_i = $urandom;
      rst_i       = $urandom_range(0, 199) == 0;
      step();
      cpu_done = (last_g == G_CPU) || !cpu_req_i || rst_i;
      dbg_done = (last_g == G_DBG) || !dbg_req_i || rst_i;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, data width of both requester ports and the memory port.
REQ-002 Parameter: ADDR_W, 32, address width of both requester ports and the memory port.
REQ-003 Parameter: CPU_WEIGHT, 4, maximum consecutive CPU grants while debug is waiting; legal range 1..15.
REQ-004 Port: clk_i  in  1  the only clock; all state changes on its rising edge.
REQ-005 Port: rst_i  in  1  asynchronous, active-high reset.
REQ-006 Port: cpu_req_i, cpu_we_i  in  1 each  CPU access request and write enable.
REQ-007 Port: cpu_addr_i, cpu_wdata_i  in  ADDR_W, DATA_W  CPU address and write data.
REQ-008 Port: cpu_gnt_o  out  1  CPU access issued this cycle.
REQ-009 Port: cpu_rvalid_o, cpu_rdata_o  out  1, DATA_W  CPU read response.
REQ-010 Port: dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1, 1, ADDR_W, DATA_W  debug/loader request fields.
REQ-011 Port: dbg_lock_i  in  1  debug requests exclusive ownership of memory.
REQ-012 Port: dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o  out  1, 1, DATA_W  debug grant and read response.
REQ-013 Port: mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o  out  1, 1, ADDR_W, DATA_W  single-port RAM command.
REQ-014 Port: mem_rdata_i  in  DATA_W  RAM read data, valid the cycle after a read command.
REQ-015 Port: cpu_stall_o  out  1  freeze request to the CPU PC register.
REQ-016 Port: locked_o  out  1  arbiter is in the LOCKED state.

Function
REQ-017 At most one of cpu_gnt_o and dbg_gnt_o SHALL be high in any cycle.
REQ-018 A grant is combinational from registered state and current requests; mem_en_o = cpu_gnt_o | dbg_gnt_o, same cycle.
REQ-019 mem_we_o, mem_addr_o and mem_wdata_o SHALL mux the granted requester's fields; all zero when no grant.
REQ-020 A requester holds req and its fields stable until its grant; the access completes in the grant cycle (a new request may be granted next cycle).
REQ-021 For a granted read (we=0), the owner's rvalid SHALL pulse exactly one cycle later with rdata = mem_rdata_i; writes never produce rvalid.
REQ-022 rdata outputs SHALL be zero whenever the corresponding rvalid is low.
REQ-023 FSM states: ARB, LOCKED; reset state ARB.
REQ-024 ARB, only one requester: grant it.
REQ-025 ARB, both requesting: grant CPU while 4-bit consecutive-grant counter < CPU_WEIGHT, otherwise grant debug.
REQ-026 Counter increments on each CPU grant while dbg_req_i is high; it clears on any debug grant, or when dbg_req_i is low; it saturates at CPU_WEIGHT.
REQ-027 ARB -> LOCKED when dbg_gnt_o and dbg_lock_i are both high in the same cycle.
REQ-028 LOCKED: the CPU is never granted; debug is granted whenever it requests.
REQ-029 LOCKED -> ARB on the first cycle with dbg_lock_i low; the CPU is eligible for grant in that same cycle.
REQ-030 cpu_stall_o = cpu_req_i & ~cpu_gnt_o, or LOCKED (stall is asserted in LOCKED even without a CPU request).
REQ-031 locked_o SHALL be high exactly while the state is LOCKED.
REQ-032 Requests are sampled only while rst_i is low; req inputs with X during reset are ignored.

Reset
REQ-033 While rst_i is high, all outputs SHALL be 0, the state SHALL be ARB and the counter SHALL be 0; the effect is asynchronous.
REQ-034 A read granted in the cycle before reset asserts SHALL produce no rvalid; the response is dropped.
REQ-035 After rst_i deasserts, the first grant may occur on the first rising edge-bounded cycle with a request.

Verification
REQ-036 CPU read only: cpu_req=1, we=0, addr=0x10, mem_rdata=0xDEADBEEF the following cycle -> cpu_gnt=1 and mem_en=1 in the same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; dbg outputs stay 0.
REQ-037 Weighted contention: both requesting continuously, CPU_WEIGHT=4 -> grant pattern C,C,C,C,D repeating; cpu_stall_o=1 exactly on the D cycles.
REQ-038 Lock: dbg_req=1, dbg_lock=1 for 6 cycles while cpu_req=1 -> 6 debug grants, locked_o=1 from the cycle after the first grant, cpu_stall_o=1 throughout; the cycle dbg_lock drops, cpu_gnt=1.
REQ-039 Back-to-back: debug write 0x55 to 0x4 granted, then CPU read of 0x4 granted the next cycle -> mem_we=1 then 0 on consecutive cycles; cpu_rvalid follows the read by one cycle; dbg_rvalid is never asserted.
REQ-040 Reset mid-read: CPU read granted, then rst_i=1 before the next edge -> cpu_rvalid stays 0, all outputs 0, locked_o=0; after release, both requesting -> CPU is granted first (counter=0).
